// File: rtl/tu_scheduler.sv
// tu_scheduler: per-TU symbol sequencer (data / FS / stuff / FE).
// Optional fractional accumulator: define TU_SCHED_FRAC_EN.
module tu_scheduler #(
  parameter int TU_SIZE = 64,
  parameter int CW      = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stream_active,
  input  logic [CW-1:0] cfg_vsym_int,
  input  logic [9:0]    cfg_vsym_frac,
  output logic          sched_stream_en,
  output logic [1:0]    sched_stream_state,
  output logic          sched_data_req,
  output logic          sched_tu_start
);

  typedef enum logic [2:0] {
    IDLE, DATA, SFS, STUFF, SFE
  } state_t;

  localparam logic [CW-1:0] TUS = CW'(TU_SIZE);

  state_t        state, state_nx;
  logic [CW-1:0] pos;
  logic [CW-1:0] n_q;
  logic [CW-1:0] s_q;
  logic          carry;
  logic [CW:0]   n_raw;
  logic [CW-1:0] n_new;
  logic          data_last;
  logic          tu_last;
  logic          tu_go;
  logic          nx_en;
  logic [1:0]    nx_st;
  logic          nx_req;
  logic          nx_start;

`ifdef TU_SCHED_FRAC_EN
  logic [9:0]  acc;
  logic [10:0] acc_next;

  assign acc_next = {1'b0, (state == IDLE) ? 10'd0 : acc}
                  + {1'b0, cfg_vsym_frac};
  assign carry    = acc_next[10];

  // Phase accumulator advances once per TU, restarts each line
  always_ff @(posedge clk) begin
    if (!rst_n)     acc <= '0;
    else if (tu_go) acc <= acc_next[9:0];
  end
`else
  logic unused_frac;
  assign unused_frac = ^cfg_vsym_frac;
  assign carry       = 1'b0;
`endif

  assign n_raw = {1'b0, cfg_vsym_int} + {{CW{1'b0}}, carry};

  // Clamp valid-symbol count to [1, TU_SIZE]
  always_comb begin
    n_new = n_raw[CW-1:0];
    if (n_raw == '0)
      n_new = CW'(1);
    else if (n_raw > {1'b0, TUS})
      n_new = TUS;
  end

  assign data_last = (state == DATA) && (pos == n_q - CW'(1));
  assign tu_last   = (data_last && (s_q == '0)) || (state == SFE);
  assign tu_go     = stream_active && ((state == IDLE) || tu_last);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state selection
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (stream_active) state_nx = DATA;
      DATA: begin
        if (data_last) begin
          if (s_q == '0)
            state_nx = stream_active ? DATA : IDLE;
          else if (s_q == CW'(1))
            state_nx = SFE;
          else
            state_nx = SFS;
        end
      end
      SFS:   state_nx = (s_q > CW'(2)) ? STUFF : SFE;
      STUFF: if (pos == TUS - CW'(2)) state_nx = SFE;
      SFE:   state_nx = stream_active ? DATA : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Position and per-TU counts, latched at TU start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos <= '0;
      n_q <= TUS;
      s_q <= '0;
    end else if (tu_go) begin
      pos <= '0;
      n_q <= n_new;
      s_q <= TUS - n_new;
    end else if (state_nx == IDLE) begin
      pos <= '0;
    end else begin
      pos <= pos + CW'(1);
    end
  end

  // Symbol decode for the current position
  always_comb begin
    nx_en    = 1'b0;
    nx_st    = 2'b00;
    nx_req   = 1'b0;
    nx_start = 1'b0;
    unique case (state)
      DATA: begin
        nx_en    = 1'b1;
        nx_st    = 2'b01;
        nx_req   = 1'b1;
        nx_start = (pos == '0);
      end
      SFS: begin
        nx_en = 1'b1;
        nx_st = 2'b10;
      end
      STUFF: nx_en = 1'b1;
      SFE: begin
        nx_en = 1'b1;
        nx_st = 2'b11;
      end
      default: ;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sched_stream_en    <= 1'b0;
      sched_stream_state <= 2'b00;
      sched_data_req     <= 1'b0;
      sched_tu_start     <= 1'b0;
    end else begin
      sched_stream_en    <= nx_en;
      sched_stream_state <= nx_st;
      sched_data_req     <= nx_req;
      sched_tu_start     <= nx_start;
    end
  end

endmodule

// File: tb/tb_tu_scheduler.sv
// tb_tu_scheduler: symbol-stream model plus directed TU scenarios.
// Honours TU_SCHED_FRAC_EN for expected n sequences.
module tb_tu_scheduler;
  localparam int TU = 64;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sa = 1'b0;
  logic [CW-1:0] vi = '0;
  logic [9:0]    vf = '0;
  logic          en;
  logic [1:0]    st;
  logic          req;
  logic          start;

  tu_scheduler #(.TU_SIZE(TU), .CW(CW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .stream_active      (sa),
    .cfg_vsym_int       (vi),
    .cfg_vsym_frac      (vf),
    .sched_stream_en    (en),
    .sched_stream_state (st),
    .sched_data_req     (req),
    .sched_tu_start     (start)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // symbol = {en, state[1:0], req, tu_start}
  logic [4:0] mq[$];
  logic [4:0] cur = '0;
  logic [4:0] expv;
  int macc = 0;
  int mc;
  int mn_now;
  int mn[$];

  int cyc = 0;
  int dn[$];
  int starts[$];
  int fs_c = 0;
  int fe_c = 0;
  int z_c = 0;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic build(int n);
    int s;
    for (int i = 0; i < n; i++)
      mq.push_back({1'b1, 2'b01, 1'b1, (i == 0)});
    s = TU - n;
    if (s >= 2) begin
      mq.push_back({1'b1, 2'b10, 2'b00});
      for (int i = 0; i < s - 2; i++)
        mq.push_back({1'b1, 2'b00, 2'b00});
      mq.push_back({1'b1, 2'b11, 2'b00});
    end else if (s == 1) begin
      mq.push_back({1'b1, 2'b11, 2'b00});
    end
  endtask

  // Model step, per-cycle compare and monitor
  always @(posedge clk) begin
    expv = rst_n ? cur : 5'd0;
    if (!rst_n) begin
      mq.delete();
      cur = '0;
    end else if (mq.size() > 0) begin
      cur = mq.pop_front();
    end else if (sa) begin
      if (!cur[4]) macc = 0;
      mc = 0;
`ifdef TU_SCHED_FRAC_EN
      macc += int'(vf);
      if (macc >= 1024) begin
        mc = 1;
        macc -= 1024;
      end
`endif
      mn_now = int'(vi) + mc;
      if (mn_now < 1) mn_now = 1;
      if (mn_now > TU) mn_now = TU;
      mn.push_back(mn_now);
      build(mn_now);
      cur = mq.pop_front();
    end else begin
      cur = '0;
    end
    #1;
    tests++;
    if ({en, st, req, start} !== expv) begin
      fails++;
      $display("FAIL sym cyc %0d: got %b expected %b",
               cyc, {en, st, req, start}, expv);
    end
    cyc++;
    if (en && start) begin
      dn.push_back(0);
      starts.push_back(cyc);
    end
    if (req && dn.size() > 0) dn[dn.size()-1] += 1;
    if (en && st == 2'b10) fs_c++;
    if (en && st == 2'b11) fe_c++;
    if (en && st == 2'b00) z_c++;
  end

  task automatic clr();
    dn.delete();
    starts.delete();
    mn.delete();
    fs_c = 0;
    fe_c = 0;
    z_c = 0;
  endtask

  task automatic run(int i, int f, int tus, int chg);
    @(negedge clk);
    clr();
    vi = CW'(i);
    vf = 10'(f);
    sa = 1'b1;
    repeat (20) @(negedge clk);
    if (chg >= 0) vi = CW'(chg);
    repeat (tus * TU - 20) @(negedge clk);
    sa = 1'b0;
    repeat (TU + 6) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Full TUs, no stuffing
    run(64, 0, 3, -1);
    chk("full_tus", dn.size(), 3);
    chk("full_n0", dn[0], 64);
    chk("full_n2", dn[2], 64);
    chk("full_period", starts[1] - starts[0], 64);
    chk("full_period2", starts[2] - starts[1], 64);
    chk("full_fs", fs_c, 0);
    chk("full_fe", fe_c, 0);

    // Four stuffing symbols
    run(60, 0, 2, -1);
    chk("s4_tus", dn.size(), 2);
    chk("s4_n0", dn[0], 60);
    chk("s4_n1", dn[1], 60);
    chk("s4_fs", fs_c, 2);
    chk("s4_z", z_c, 4);
    chk("s4_fe", fe_c, 2);

    // s=1 with a mid-TU config change that must be ignored
    run(63, 0, 1, 10);
    chk("s1_n", dn[0], 63);
    chk("s1_fs", fs_c, 0);
    chk("s1_fe", fe_c, 1);

    run(62, 0, 1, -1);
    chk("s2_n", dn[0], 62);
    chk("s2_fs", fs_c, 1);
    chk("s2_z", z_c, 0);
    chk("s2_fe", fe_c, 1);

    // Fractional count
    run(40, 512, 4, -1);
    chk("frac_tus", dn.size(), 4);
`ifdef TU_SCHED_FRAC_EN
    chk("frac_m0", mn[0], 40);
    chk("frac_m1", mn[1], 41);
    chk("frac_d2", dn[2], 40);
    chk("frac_d3", dn[3], 41);
`else
    chk("frac_m0", mn[0], 40);
    chk("frac_m1", mn[1], 40);
    chk("frac_d2", dn[2], 40);
    chk("frac_d3", dn[3], 40);
`endif

    // Clamps
    run(0, 0, 1, -1);
    chk("clamp_lo_m", mn[0], 1);
    chk("clamp_lo_d", dn[0], 1);
    run(127, 0, 1, -1);
    chk("clamp_hi_d", dn[0], 64);
    run(64, 1023, 2, -1);
    chk("clamp_c_m1", mn[1], 64);
    chk("clamp_c_d1", dn[1], 64);

    // stream_active drops early: TU still completes
    @(negedge clk);
    clr();
    vi = CW'(50);
    vf = '0;
    sa = 1'b1;
    repeat (11) @(negedge clk);
    sa = 1'b0;
    repeat (TU + 6) @(negedge clk);
    chk("drop_tus", starts.size(), 1);
    chk("drop_n", dn[0], 50);
    chk("drop_fs", fs_c, 1);
    chk("drop_z", z_c, 12);
    chk("drop_fe", fe_c, 1);

    // Reset mid-TU, recovery with stream still active
    @(negedge clk);
    clr();
    vi = CW'(50);
    vf = '0;
    sa = 1'b1;
    repeat (31) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out", {27'd0, en, st, req, start}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_gap", {27'd0, en, st, req, start}, 0);
    @(posedge clk);
    #1;
    chk("rst_restart", start, 1);
    @(negedge clk);
    repeat (TU) @(negedge clk);
    sa = 1'b0;
    repeat (TU + 6) @(negedge clk);
    chk("rst_n_after", dn[1], 50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
